// File: rtl/deinterleaver_top.sv
// Receive-side block bit deinterleaver for the WiMAX OFDM PHY.
// Interleaved coded bits are written into a ping-pong pair of Ncbps-bit banks
// at their de-permuted address. A full bank is then streamed out in FEC order.
// Both sides use valid/ready handshakes.
module deinterleaver_top #(
  parameter int Ncbps = 192,
  parameter int Ncpc  = 2,
  parameter int s     = Ncpc / 2,
  parameter int d     = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  output logic data_out,
  output logic valid_out,
  input  logic ready_in
);

  localparam int AW   = $clog2(Ncbps);
  localparam int COLS = Ncbps / d;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (d > 1) ? $clog2(d) : 1;
  localparam logic [AW-1:0] LAST = AW'(Ncbps - 1);

  // Inverse of the transmit permutation; only evaluated at elaboration.
  function automatic int k_of(input int jj);
    int m;
    m = s * (jj / s) + ((jj + (d * jj) / Ncbps) % s);
    return d * m - (Ncbps - 1) * ((d * m) / Ncbps);
  endfunction

  logic [Ncbps-1:0] bank [2];
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [AW-1:0]    j;
  logic [AW-1:0]    r;
  logic [AW-1:0]    k;
  logic             in_xfer;
  logic             wr_last;
  logic             rd_load;
  logic             rd_last;

  // Input is accepted only while the bank being filled is free; held low in reset.
  assign ready_out = resetN & ~full[wr_sel];
  assign in_xfer   = valid_in & ready_out;
  assign wr_last   = in_xfer && (j == LAST);

  // A new bit is loaded whenever the output register is empty or being consumed.
  assign rd_load   = full[rd_sel] & (~valid_out | ready_in);
  assign rd_last   = rd_load && (r == LAST);

  generate
    if (s == 1) begin : g_ctr
      // For s=1 the address is d*col + row; col/row are walked incrementally so
      // k steps by d along a row and restarts at the next row index on wrap.
      logic [CW-1:0] col;
      logic [RW-1:0] row;
      logic [AW-1:0] k_reg;

      // Row/column walk of the write address.
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          col   <= '0;
          row   <= '0;
          k_reg <= '0;
        end else if (in_xfer) begin
          if (wr_last) begin
            col   <= '0;
            row   <= '0;
            k_reg <= '0;
          end else if (col == CW'(COLS - 1)) begin
            col   <= '0;
            row   <= row + 1'b1;
            k_reg <= AW'(row) + 1'b1;
          end else begin
            col   <= col + 1'b1;
            k_reg <= k_reg + AW'(d);
          end
        end
      end

      assign k = k_reg;
    end else begin : g_tab
      // For s>1 the second permutation breaks the simple stride, so the
      // address comes from a constant table indexed by j.
      logic [AW-1:0] k_tab [Ncbps];
      for (genvar i = 0; i < Ncbps; i++) begin : g_ent
        assign k_tab[i] = AW'(k_of(i));
      end
      assign k = k_tab[j];
    end
  endgenerate

  // Write-side bit counter and bank pointer.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      j      <= '0;
      wr_sel <= 1'b0;
    end else if (in_xfer) begin
      if (wr_last) begin
        j      <= '0;
        wr_sel <= ~wr_sel;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

  // Full flags: set by the writer on its last bit, cleared by the reader on its
  // last load. Both can fire in one cycle but always on different banks.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      full <= 2'b00;
    end else begin
      if (wr_last) full[wr_sel] <= 1'b1;
      if (rd_last) full[rd_sel] <= 1'b0;
    end
  end

  // Bank storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) bank[wr_sel][k] <= data_in;
  end

  // Read side: registered output that holds under backpressure.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r         <= '0;
      rd_sel    <= 1'b0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
    end else if (rd_load) begin
      data_out  <= bank[rd_sel][r];
      valid_out <= 1'b1;
      if (rd_last) begin
        r      <= '0;
        rd_sel <= ~rd_sel;
      end else begin
        r <= r + 1'b1;
      end
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deinterleaver_top.sv
// Bench for deinterleaver_top: a QPSK instance (192/2/1/16) and a 16QAM
// instance (384/4/2/16) share one stimulus/collection loop through a selector.
module tb_deinterleaver_top;

  localparam logic [191:0] GIN  = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
  localparam logic [191:0] GOUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic resetN;
  logic vin, din, rin;
  int   sel;

  logic q_vi, q_di, q_ri, q_ro, q_do, q_vo;
  logic a_vi, a_di, a_ri, a_ro, a_do, a_vo;
  logic ro, dout, vo;

  assign q_vi = (sel == 0) ? vin : 1'b0;
  assign q_di = din;
  assign q_ri = (sel == 0) ? rin : 1'b0;
  assign a_vi = (sel == 1) ? vin : 1'b0;
  assign a_di = din;
  assign a_ri = (sel == 1) ? rin : 1'b0;
  assign ro   = (sel == 1) ? a_ro : q_ro;
  assign dout = (sel == 1) ? a_do : q_do;
  assign vo   = (sel == 1) ? a_vo : q_vo;

  deinterleaver_top u_qpsk (
    .clk(clk), .resetN(resetN), .data_in(q_di), .valid_in(q_vi),
    .ready_out(q_ro), .data_out(q_do), .valid_out(q_vo), .ready_in(q_ri)
  );

  deinterleaver_top #(.Ncbps(384), .Ncpc(4), .s(2), .d(16)) u_qam (
    .clk(clk), .resetN(resetN), .data_in(a_di), .valid_in(a_vi),
    .ready_out(a_ro), .data_out(a_do), .valid_out(a_vo), .ready_in(a_ri)
  );

  int total = 0;
  int bad   = 0;

  logic tx_q[$];
  logic exp_q[$];
  logic rx_q[$];

  int acc, first_v, nth_edge, bubbles, hold_viol, acc_at_drop, out_at_rise;
  bit run_done;

  typedef struct {
    logic [191:0] din;
    logic [191:0] dout;
    int           pin;
    int           pout;
  } vec_t;
  vec_t tbl[8];

  task automatic chk_int(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [383:0] got, input logic [383:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Reference deinterleave address (receive rule).
  function automatic int kdi(input int j, input int n, input int ss, input int dd);
    int m;
    m = ss * (j / ss) + ((j + (dd * j) / n) % ss);
    return dd * m - (n - 1) * ((dd * m) / n);
  endfunction

  // Reference transmit interleave address (forward rule).
  function automatic int jtx(input int k, input int n, input int ss, input int dd);
    int m;
    m = (n / dd) * (k % dd) + k / dd;
    return ss * (m / ss) + ((m + n - (dd * m) / n) % ss);
  endfunction

  task automatic push_tx(input logic [191:0] v);
    for (int i = 0; i < 192; i++) tx_q.push_back(v[191-i]);
  endtask

  task automatic push_exp(input logic [191:0] v);
    for (int i = 0; i < 192; i++) exp_q.push_back(v[191-i]);
  endtask

  task automatic clear_q();
    tx_q.delete();
    exp_q.delete();
    rx_q.delete();
  endtask

  // Random QPSK block, expected output from the receive address rule.
  task automatic push_rand_qpsk();
    logic blk[192];
    logic outb[192];
    for (int j = 0; j < 192; j++) blk[j] = 1'($urandom_range(1));
    for (int j = 0; j < 192; j++) outb[kdi(j, 192, 1, 16)] = blk[j];
    for (int j = 0; j < 192; j++) begin
      tx_q.push_back(blk[j]);
      exp_q.push_back(outb[j]);
    end
  endtask

  // Random 16QAM block passed through the transmit interleaver; expect the original.
  task automatic push_rand_qam();
    logic blk[384];
    logic txb[384];
    for (int k = 0; k < 384; k++) blk[k] = 1'($urandom_range(1));
    for (int k = 0; k < 384; k++) txb[jtx(k, 384, 2, 16)] = blk[k];
    for (int j = 0; j < 384; j++) begin
      tx_q.push_back(txb[j]);
      exp_q.push_back(blk[j]);
    end
  endtask

  // Per-cycle driver/collector; starts and ends on a falling edge.
  task automatic run(input int n, input int pin, input int pout, input int hold,
                     input int stop_acc, input int budget);
    int   ti;
    logic pv, pr, pd;
    bit   dropped;
    ti = 0; acc = 0; first_v = -1; nth_edge = -1; bubbles = 0; hold_viol = 0;
    acc_at_drop = -1; out_at_rise = -1; dropped = 0; run_done = 0;
    rx_q.delete();
    pv = 1'b0; pr = 1'b0; pd = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (stop_acc > 0 && acc >= stop_acc) begin run_done = 1; break; end
      if (stop_acc == 0 && rx_q.size() >= exp_q.size()) begin run_done = 1; break; end
      vin = (ti < tx_q.size()) && (int'($urandom_range(99)) >= pin);
      din = vin ? tx_q[ti] : 1'($urandom_range(1));
      rin = (c >= hold) && (int'($urandom_range(99)) >= pout);
      #1;
      if (pv && !pr && (vo !== 1'b1 || dout !== pd)) hold_viol++;
      if (!ro && !dropped && acc > 0) begin dropped = 1; acc_at_drop = acc; end
      if (ro && dropped && out_at_rise < 0) out_at_rise = rx_q.size();
      if (vo && first_v < 0) first_v = cyc;
      if (first_v >= 0 && !vo && rx_q.size() < exp_q.size()) bubbles++;
      if (vo && rin) rx_q.push_back(dout);
      if (vin && ro) begin
        ti++; acc++;
        if (acc == n) nth_edge = cyc + 1;
      end
      pv = vo; pr = rin; pd = dout;
      @(negedge clk);
    end
    vin = 1'b0; rin = 1'b0;
    chk_int("run_complete", int'(run_done), 1);
  endtask

  task automatic check_blocks(input int n, input string nm);
    logic [383:0] got, want;
    chk_int({nm, "_count"}, rx_q.size(), exp_q.size());
    for (int b = 0; b * n < exp_q.size(); b++) begin
      got = '0; want = '0;
      for (int i = 0; i < n; i++) begin
        want[n-1-i] = exp_q[b*n+i];
        got[n-1-i]  = (b * n + i < rx_q.size()) ? rx_q[b*n+i] : 1'bx;
      end
      chk_vec($sformatf("%s_blk%0d", nm, b), got, want);
    end
  endtask

  task automatic do_reset();
    vin = 1'b0; rin = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; vin = 1'b0; din = 1'b0; rin = 1'b0; resetN = 1'b1;

    // Reset state
    #2 resetN = 1'b0;
    #1;
    chk_bit("rst_ready_out", ro, 1'b0);
    chk_bit("rst_valid_out", vo, 1'b0);
    chk_bit("rst_data_out",  dout, 1'b0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    #1;
    chk_bit("ready_after_release", ro, 1'b1);
    @(negedge clk);

    // Golden block with latency
    clear_q(); push_tx(GIN); push_exp(GOUT);
    run(192, 0, 0, 0, 0, 2000);
    check_blocks(192, "golden");
    chk_int("first_valid_latency", first_v, nth_edge + 1);

    // Table of fixed vectors
    tbl[0] = '{GIN, GOUT, 0, 0};
    tbl[1] = '{192'd0, 192'd0, 0, 0};
    tbl[2] = '{{192{1'b1}}, {192{1'b1}}, 20, 20};
    tbl[3] = '{192'd1 << 190, 192'd1 << 175, 0, 0};   // j=1   -> k=16
    tbl[4] = '{192'd1 << 179, 192'd1 << 190, 0, 0};   // j=12  -> k=1
    tbl[5] = '{192'd1 << 178, 192'd1 << 174, 10, 10}; // j=13  -> k=17
    tbl[6] = '{192'd1 << 11,  192'd1 << 176, 0, 0};   // j=180 -> k=15
    tbl[7] = '{192'd1, 192'd1, 30, 30};               // j=191 -> k=191
    for (int t = 0; t < 8; t++) begin
      clear_q(); push_tx(tbl[t].din); push_exp(tbl[t].dout);
      run(192, tbl[t].pin, tbl[t].pout, 0, 0, 3000);
      check_blocks(192, $sformatf("tbl%0d", t));
    end

    // Streaming: five back-to-back golden blocks
    clear_q();
    for (int b = 0; b < 5; b++) begin push_tx(GIN); push_exp(GOUT); end
    run(192, 0, 0, 0, 0, 3000);
    check_blocks(192, "stream");
    chk_int("stream_bubbles", bubbles, 0);

    // Backpressure: downstream stalled for 400 cycles
    do_reset();
    @(negedge clk);
    clear_q();
    for (int b = 0; b < 3; b++) begin push_tx(GIN); push_exp(GOUT); end
    run(192, 0, 0, 400, 0, 4000);
    check_blocks(192, "bp");
    chk_int("bp_accepted_at_stall", acc_at_drop, 384);
    chk_int("bp_out_count_at_ready", out_at_rise, 191);
    chk_int("bp_hold_violations", hold_viol, 0);

    // Random gaps, golden and random-data blocks
    clear_q();
    for (int b = 0; b < 3; b++) begin push_tx(GIN); push_exp(GOUT); end
    for (int b = 0; b < 3; b++) push_rand_qpsk();
    run(192, 30, 30, 0, 0, 6000);
    check_blocks(192, "gaps");
    chk_int("gaps_hold_violations", hold_viol, 0);

    // Reset in the middle of the second block (input bit 100)
    clear_q();
    for (int b = 0; b < 2; b++) begin push_tx(GIN); push_exp(GOUT); end
    run(192, 0, 0, 0, 292, 2000);
    chk_bit("pre_reset_valid", vo, 1'b1);
    resetN = 1'b0;
    #1;
    chk_bit("midrst_valid_out", vo, 1'b0);
    chk_bit("midrst_data_out",  dout, 1'b0);
    chk_bit("midrst_ready_out", ro, 1'b0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    #1;
    chk_bit("midrst_ready_release", ro, 1'b1);
    @(negedge clk);
    clear_q(); push_tx(GIN); push_exp(GOUT);
    run(192, 0, 0, 0, 0, 2000);
    check_blocks(192, "after_rst");

    // 16QAM round trip through the transmit interleaver
    sel = 1;
    do_reset();
    @(negedge clk);
    clear_q();
    for (int b = 0; b < 2; b++) push_rand_qam();
    run(384, 0, 0, 0, 0, 3000);
    check_blocks(384, "qam_rt");
    clear_q();
    for (int b = 0; b < 3; b++) push_rand_qam();
    run(384, 30, 30, 0, 0, 8000);
    check_blocks(384, "qam_rt_gaps");
    chk_int("qam_hold_violations", hold_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
